pipe_stage_hs: RTL and testbench

//  Parametrised pipeline stage register with valid/ready handshake, stall (en) and flush.

---
 rtl/pipe_pkg.sv | 22 ++
 rtl/pipe_skid_slot.sv | 37 +++
 rtl/pipe_stage_hs.sv | 158 +++++++++++++++
 tb/tb_pipe_stage_hs.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared defaults and encodings for the handshake pipeline stage register.
// The optional skid slot is enabled by defining PIPE_STAGE_SKID_EN.
package pipe_pkg;

  localparam int CTRL_W_DEF = 5;
  localparam int DATA_W_DEF = 102;

  // Occupancy encoding doubles as the skid-variant FSM state and the occ output value.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_BUSY  = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  // Bubble control bit; replicated to CTRL_W so a flushed stage is a no-op downstream.
  localparam logic BUBBLE_CTRL_BIT = 1'b0;

  function automatic logic [1:0] occ_bits(input occ_e s);
    return logic'(s[1]) ? 2'd2 : {1'b0, s[0]};
  endfunction

endpackage

// File: rtl/pipe_skid_slot.sv
// One-entry ctrl+data holding register used as the skid buffer of pipe_stage_hs.
// Clear zeroes the control field only, mirroring the output-register bubble behaviour.
module pipe_skid_slot
  import pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_clear,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic [DATA_W-1:0] i_data,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [DATA_W-1:0] o_data
);

  logic [CTRL_W-1:0] r_ctrl;
  logic [DATA_W-1:0] r_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctrl <= {CTRL_W{BUBBLE_CTRL_BIT}};
      r_data <= '0;
    end else if (i_clear) begin
      r_ctrl <= {CTRL_W{BUBBLE_CTRL_BIT}};
    end else if (i_load) begin
      r_ctrl <= i_ctrl;
      r_data <= i_data;
    end
  end

  assign o_ctrl = r_ctrl;
  assign o_data = r_data;

endmodule

// File: rtl/pipe_stage_hs.sv
// Pipeline stage register with valid/ready handshake, stall (en) and flush (bubble insert).
// Define PIPE_STAGE_SKID_EN to add one skid slot and register in_ready.
module pipe_stage_hs
  import pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occ
);

  logic [CTRL_W-1:0] r_out_ctrl;
  logic [DATA_W-1:0] r_out_data;
  logic              w_in_ready;
  logic              w_out_valid;
  logic              w_accept;
  logic              w_consume;

  assign w_accept  = in_valid & w_in_ready;
  assign w_consume = w_out_valid & out_ready & en;

`ifdef PIPE_STAGE_SKID_EN

  occ_e              r_state;
  occ_e              w_state_nxt;
  logic              r_in_ready;
  logic              w_load_out;
  logic              w_out_from_skid;
  logic              w_load_skid;
  logic [CTRL_W-1:0] w_skid_ctrl;
  logic [DATA_W-1:0] w_skid_data;

  assign w_in_ready  = en & r_in_ready;
  assign w_out_valid = (r_state != OCC_EMPTY);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt     = r_state;
    w_load_out      = 1'b0;
    w_out_from_skid = 1'b0;
    w_load_skid     = 1'b0;
    if (flush) begin
      w_state_nxt = OCC_EMPTY;
    end else if (en) begin
      unique case (r_state)
        OCC_EMPTY: begin
          if (w_accept) begin
            w_state_nxt = OCC_BUSY;
            w_load_out  = 1'b1;
          end
        end
        OCC_BUSY: begin
          if (w_accept && w_consume) begin
            w_load_out = 1'b1;
          end else if (w_accept) begin
            w_state_nxt = OCC_FULL;
            w_load_skid = 1'b1;
          end else if (w_consume) begin
            w_state_nxt = OCC_EMPTY;
          end
        end
        OCC_FULL: begin
          if (w_consume) begin
            w_state_nxt     = OCC_BUSY;
            w_load_out      = 1'b1;
            w_out_from_skid = 1'b1;
          end
        end
        default: w_state_nxt = OCC_EMPTY;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= OCC_EMPTY;
      r_in_ready <= 1'b1;
      r_out_ctrl <= {CTRL_W{BUBBLE_CTRL_BIT}};
      // NOTE: the wide payload is reset too, since out_data must read zero out of reset.
      r_out_data <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != OCC_FULL);
      if (flush) begin
        r_out_ctrl <= {CTRL_W{BUBBLE_CTRL_BIT}};
      end else if (w_load_out) begin
        r_out_ctrl <= w_out_from_skid ? w_skid_ctrl : in_ctrl;
        r_out_data <= w_out_from_skid ? w_skid_data : in_data;
      end
    end
  end

  pipe_skid_slot #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load_skid),
    .i_clear (flush),
    .i_ctrl  (in_ctrl),
    .i_data  (in_data),
    .o_ctrl  (w_skid_ctrl),
    .o_data  (w_skid_data)
  );

  assign occ = occ_bits(r_state);

`else

  logic r_out_valid;

  // Ready is combinational from out_ready: a held beat leaving frees the stage this cycle.
  assign w_in_ready  = en & (~r_out_valid | out_ready);
  assign w_out_valid = r_out_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_ctrl  <= {CTRL_W{BUBBLE_CTRL_BIT}};
      r_out_data  <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
      r_out_ctrl  <= {CTRL_W{BUBBLE_CTRL_BIT}};
    end else if (en) begin
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_out_ctrl  <= in_ctrl;
        r_out_data  <= in_data;
      end else if (w_consume) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign occ = occ_bits(r_out_valid ? OCC_BUSY : OCC_EMPTY);

`endif

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign out_ctrl  = r_out_ctrl;
  assign out_data  = r_out_data;

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Directed self-checking bench for pipe_stage_hs; expectations follow PIPE_STAGE_SKID_EN.
module tb_pipe_stage_hs;
  import pipe_pkg::*;

  localparam int CW = CTRL_W_DEF;
  localparam int DW = DATA_W_DEF;
`ifdef PIPE_STAGE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, en, flush, in_valid, out_ready;
  logic          in_ready, out_valid;
  logic [CW-1:0] in_ctrl, out_ctrl;
  logic [DW-1:0] in_data, out_data;
  logic [1:0]    occ;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  pipe_stage_hs #(.CTRL_W(CW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .occ       (occ)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs driven afterwards are stable well before the next one.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d, input logic r);
    in_valid  = v;
    in_ctrl   = c;
    in_data   = d;
    out_ready = r;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b1; flush = 1'b0;
    drive(1'b1, 5'h1B, 102'h3A5, 1'b1);

    // 1. reset
    tick(); tick();
    check("rst_valid", out_valid, 0);
    check("rst_ctrl",  out_ctrl,  0);
    check("rst_data",  out_data,  0);
    check("rst_occ",   occ,       0);
    rst = 1'b0;
    drive(1'b0, '0, '0, 1'b1);
    settle();
    check("rst_in_ready", in_ready, 1);

    // 2. stream 1..8 at full rate
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, CW'(i), DW'(i), 1'b1);
      tick();
      check("stream_valid", out_valid, 1);
      check("stream_data",  out_data,  i);
      check("stream_ctrl",  out_ctrl,  i);
      check("stream_occ",   occ,       1);
    end
    drive(1'b0, '0, '0, 1'b1);
    tick();
    check("drain_valid", out_valid, 0);
    check("drain_hold",  out_data,  8);
    check("drain_occ",   occ,       0);

    // 3. backpressure: A held, B offered
    drive(1'b1, 5'h03, 102'hA, 1'b0);
    tick();
    check("bp_a_data", out_data, 'hA);
    check("bp_a_occ",  occ,      1);
    drive(1'b1, 5'h04, 102'hB, 1'b0);
    settle();
    check("bp_b_ready", in_ready, SKID ? 1 : 0);
    tick();
    check("bp_stall_data",  out_data, 'hA);
    check("bp_stall_occ",   occ,      SKID ? 2 : 1);
    check("bp_stall_ready", in_ready, 0);
    out_ready = 1'b1;
    settle();
    check("bp_out_a", out_data, 'hA);
    tick();
    drive(1'b0, '0, '0, 1'b1);
    check("bp_out_b",     out_data,  'hB);
    check("bp_out_b_occ", occ,       1);
    tick();
    check("bp_empty_valid", out_valid, 0);
    check("bp_empty_occ",   occ,       0);

    // 4. flush with an input beat presented
    drive(1'b1, 5'h1F, 102'h55, 1'b0);
    tick();
    check("fl_pre_ctrl", out_ctrl, 'h1F);
    check("fl_pre_occ",  occ,      1);
    flush = 1'b1;
    drive(1'b1, 5'h0A, 102'h66, 1'b0);
    tick();
    flush = 1'b0;
    drive(1'b0, '0, '0, 1'b1);
    check("fl_valid", out_valid, 0);
    check("fl_ctrl",  out_ctrl,  0);
    check("fl_occ",   occ,       0);
    check("fl_data",  out_data,  'h55);
    settle();
    check("fl_ready", in_ready, 1);
    tick();
    check("fl_no_beat", out_valid, 0);

    // 5. stall for three cycles, then resume in order
    drive(1'b1, 5'h01, 102'h21, 1'b1);
    tick();
    check("st_pre_data", out_data, 'h21);
    en = 1'b0;
    drive(1'b1, 5'h02, 102'h22, 1'b1);
    settle();
    check("st_ready", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("st_hold_valid", out_valid, 1);
      check("st_hold_data",  out_data,  'h21);
      check("st_hold_occ",   occ,       1);
    end
    en = 1'b1;
    tick();
    check("st_res_22", out_data, 'h22);
    drive(1'b1, 5'h03, 102'h23, 1'b1);
    tick();
    check("st_res_23", out_data, 'h23);
    // flush wins over a stall
    en = 1'b0; flush = 1'b1;
    drive(1'b0, '0, '0, 1'b0);
    tick();
    en = 1'b1; flush = 1'b0;
    check("fl_en0_valid", out_valid, 0);
    check("fl_en0_ctrl",  out_ctrl,  0);

    // 6. reset while the stage is holding beats
    drive(1'b1, 5'h07, 102'h31, 1'b0);
    tick();
    drive(1'b1, 5'h08, 102'h32, 1'b0);
    tick();
    check("r6_occ", occ, SKID ? 2 : 1);
    rst = 1'b1;
    drive(1'b0, '0, '0, 1'b1);
    tick();
    check("r6_valid", out_valid, 0);
    check("r6_ctrl",  out_ctrl,  0);
    check("r6_data",  out_data,  0);
    check("r6_occ",   occ,       0);
    rst = 1'b0;
    settle();
    check("r6_ready", in_ready, 1);
    tick();
    check("r6_lost", out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
